// File: rtl/uart_cmd_parser.sv
// ASCII command engine: parses host text into single Wishbone reads/writes
// and streams the ASCII reply ("K", "E", "?" or 8 hex digits) to the UART.
module uart_cmd_parser #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_rx_stb,
  input  logic [7:0]    i_rx_data,
  output logic          o_tx_stb,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT, REPLY} state_t;
  typedef enum logic [1:0] {TGT_NONE, TGT_ADDR, TGT_DATA} target_t;
  typedef enum logic [1:0] {RPL_READ, RPL_OK, RPL_ERR, RPL_HUH} reply_t;

  state_t        state_q;
  target_t       target_q;
  reply_t        reply_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          we_q, cyc_q, stb_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    idx_q;
  logic          txStb_q;
  logic [7:0]    txData_q;

  logic          rxHex_d, rxBlank_d, timeout_d, txAccept_d;
  logic [3:0]    rxNib_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   data_d;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [7:0] replyByte(input reply_t kind, input logic [3:0] idx,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word << {idx, 2'b00};
    case (kind)
      RPL_READ: return (idx < 4'd8) ? hexChar(sh[31:28]) : 8'h0a;
      RPL_OK:   return (idx == 4'd0) ? "K" : 8'h0a;
      RPL_ERR:  return (idx == 4'd0) ? "E" : 8'h0a;
      default:  return (idx == 4'd0) ? "?" : 8'h0a;
    endcase
  endfunction

  always_comb begin
    rxHex_d    = ((i_rx_data >= "0") && (i_rx_data <= "9")) ||
                 ((i_rx_data >= "a") && (i_rx_data <= "f"));
    rxNib_d    = (i_rx_data <= "9") ? i_rx_data[3:0] : (i_rx_data[3:0] + 4'd9);
    rxBlank_d  = (i_rx_data == "X") || (i_rx_data == 8'h0d) ||
                 (i_rx_data == 8'h0a) || (i_rx_data == 8'h20);
    addr_d     = {addr_q[AW-5:0], rxNib_d};
    data_d     = {data_q[27:0], rxNib_d};
    timeout_d  = (state_q == BUS_WAIT) && (timer_q == TW'(TIMEOUT - 1));
    txAccept_d = txStb_q && !i_tx_busy;
  end

  // Error and timeout outrank ack; an ack seen while still requesting
  // finishes the cycle just as it would after the request was accepted.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      target_q <= TGT_NONE;
      reply_q  <= RPL_OK;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      timer_q  <= '0;
      idx_q    <= '0;
      txStb_q  <= 1'b0;
      txData_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_rx_stb) begin
            if (i_rx_data == "A") begin
              addr_q   <= '0;
              target_q <= TGT_ADDR;
            end else if (i_rx_data == "D") begin
              data_q   <= '0;
              target_q <= TGT_DATA;
            end else if (rxHex_d) begin
              if (target_q == TGT_ADDR) addr_q <= addr_d;
              else if (target_q == TGT_DATA) data_q <= data_d;
            end else if ((i_rx_data == "R") || (i_rx_data == "W")) begin
              we_q    <= (i_rx_data == "W");
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              timer_q <= '0;
              state_q <= BUS_REQ;
            end else if (rxBlank_d) begin
              target_q <= TGT_NONE;
            end else begin
              target_q <= TGT_NONE;
              reply_q  <= RPL_HUH;
              idx_q    <= '0;
              txStb_q  <= 1'b1;
              txData_q <= "?";
              state_q  <= REPLY;
            end
          end
        end
        BUS_REQ, BUS_WAIT: begin
          if (i_wb_err || timeout_d) begin
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            reply_q  <= RPL_ERR;
            idx_q    <= '0;
            txStb_q  <= 1'b1;
            txData_q <= "E";
            state_q  <= REPLY;
          end else if (i_wb_ack) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            idx_q   <= '0;
            txStb_q <= 1'b1;
            state_q <= REPLY;
            if (we_q) begin
              reply_q  <= RPL_OK;
              txData_q <= "K";
            end else begin
              data_q   <= i_wb_data;
              reply_q  <= RPL_READ;
              txData_q <= hexChar(i_wb_data[31:28]);
            end
          end else if ((state_q == BUS_REQ) && !i_wb_stall) begin
            stb_q   <= 1'b0;
            timer_q <= '0;
            state_q <= BUS_WAIT;
          end else if (state_q == BUS_WAIT) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        REPLY: begin
          if (txAccept_d) begin
            if (idx_q == ((reply_q == RPL_READ) ? 4'd8 : 4'd1)) begin
              txStb_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q    <= idx_q + 4'd1;
              txData_q <= replyByte(reply_q, idx_q + 4'd1, data_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_stb  = txStb_q;
  assign o_tx_data = txData_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;
  assign o_wb_sel  = 4'hf;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser: a text-level model of the command
// registers and reply strings, with the bench acting as Wishbone slave and UART TX.
module tb_uart_cmd_parser;
  localparam int AW = 30;
  localparam int TO = 40;
  localparam logic [63:0] AMASK = (64'd1 << AW) - 64'd1;

  logic          clk = 1'b0;
  logic          rstN;
  logic          rxStb;
  logic [7:0]    rxData;
  logic          txStb;
  logic [7:0]    txData;
  logic          txBusy;
  logic          wbCyc, wbStb, wbWe;
  logic [AW-1:0] wbAddr;
  logic [31:0]   wbDataO;
  logic [3:0]    wbSel;
  logic          wbStall, wbAck, wbErr;
  logic [31:0]   wbDataI;

  int vecCount  = 0;
  int missCount = 0;

  logic [63:0] addrM, dataM;
  int          targetM;
  string       hexChars = "0123456789abcdef";

  uart_cmd_parser #(.AW(AW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rstN),
    .i_rx_stb(rxStb), .i_rx_data(rxData),
    .o_tx_stb(txStb), .o_tx_data(txData), .i_tx_busy(txBusy),
    .o_wb_cyc(wbCyc), .o_wb_stb(wbStb), .o_wb_we(wbWe),
    .o_wb_addr(wbAddr), .o_wb_data(wbDataO), .o_wb_sel(wbSel),
    .i_wb_stall(wbStall), .i_wb_ack(wbAck), .i_wb_err(wbErr), .i_wb_data(wbDataI)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    addrM = 0; dataM = 0; targetM = 0;
  endtask

  // Text-level meaning of one received byte in the idle state.
  task automatic modelByte(input logic [7:0] c, output string reply);
    int v;
    reply = "";
    v = -1;
    if (c >= "0" && c <= "9") v = int'(c) - 48;
    else if (c >= "a" && c <= "f") v = int'(c) - 87;
    if (c == "A") begin addrM = 0; targetM = 1; end
    else if (c == "D") begin dataM = 0; targetM = 2; end
    else if (v >= 0) begin
      if (targetM == 1) addrM = (addrM * 16 + 64'(v)) & AMASK;
      else if (targetM == 2) dataM = (dataM * 16 + 64'(v)) & 64'hffff_ffff;
    end
    else if (c == "X" || c == 8'h0d || c == 8'h0a || c == 8'h20) targetM = 0;
    else begin targetM = 0; reply = "?\n"; end
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    @(negedge clk);
    rxStb = 1'b1; rxData = c;
    @(negedge clk);
    rxStb = 1'b0;
  endtask

  // Act as the UART transmitter with random busy, checking held bytes stay put.
  task automatic collectReply(input string exp);
    int got = 0, cyc = 0;
    logic held = 1'b0;
    logic [7:0] heldData = 8'h00;
    while (got < exp.len() && cyc < 300) begin
      if (held) checkOutput("txHold", {txStb, txData}, {1'b1, heldData});
      txBusy = ($urandom_range(0, 2) == 0);
      if (txStb && !txBusy) begin
        checkOutput($sformatf("txByte%0d", got), txData, exp[got]);
        got++;
        held = 1'b0;
      end else begin
        held = txStb; heldData = txData;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < exp.len()) checkOutput("replyTimeout", got, exp.len());
    txBusy = 1'b0;
    checkOutput("txDone", txStb, 0);
  endtask

  task automatic sendChar(input logic [7:0] c);
    string r;
    applyStimulus(c);
    modelByte(c, r);
    if (r.len() > 0) collectReply(r);
  endtask

  task automatic sendText(input string s);
    for (int i = 0; i < s.len(); i++) sendChar(s[i]);
  endtask

  // mode: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout)
  task automatic wbRun(input int stalls, input int lat, input int mode, input logic [31:0] rdata,
                       input bit weExp, input bit dropByte);
    int n;
    checkOutput("cycReq", wbCyc, 1);
    checkOutput("stbReq", wbStb, 1);
    checkOutput("addrReq", wbAddr, addrM);
    checkOutput("weReq", wbWe, weExp);
    checkOutput("selReq", wbSel, 4'hf);
    if (weExp) checkOutput("dataReq", wbDataO, dataM);
    for (int i = 0; i < stalls; i++) begin
      wbStall = 1'b1;
      if (dropByte && i == 0) begin rxStb = 1'b1; rxData = "A"; end
      @(negedge clk);
      rxStb = 1'b0;
      checkOutput("stbStall", wbStb, 1);
    end
    wbStall = 1'b0;
    @(negedge clk);
    checkOutput("stbWait", wbStb, 0);
    checkOutput("cycWait", wbCyc, 1);
    if (mode == 3) begin
      n = 1;
      while (wbCyc && n < TO + 10) begin
        @(negedge clk);
        if (wbCyc) n++;
      end
      checkOutput("timeoutLen", n, TO);
    end else begin
      repeat (lat) @(negedge clk);
      wbAck = (mode != 1); wbErr = (mode != 0); wbDataI = rdata;
      @(negedge clk);
      wbAck = 1'b0; wbErr = 1'b0; wbDataI = $urandom;
      checkOutput("cycDone", wbCyc, 0);
    end
  endtask

  task automatic doOp(input bit isWrite, input int stalls, input int lat, input int mode,
                      input logic [31:0] rdata, input bit dropByte);
    applyStimulus(isWrite ? "W" : "R");
    wbRun(stalls, lat, mode, rdata, isWrite, dropByte);
    if (mode == 0) collectReply(isWrite ? "K\n" : $sformatf("%08x\n", rdata));
    else collectReply("E\n");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit   doWrite;
    int   nd, mode;
    rstN = 1'b0; rxStb = 1'b0; rxData = 8'h00; txBusy = 1'b0;
    wbStall = 1'b0; wbAck = 1'b0; wbErr = 1'b0; wbDataI = 32'h0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rstTx", {txStb, txData}, 0);
    checkOutput("rstWb", {wbCyc, wbStb, wbWe}, 0);
    checkOutput("rstAddr", wbAddr, 0);
    checkOutput("rstData", wbDataO, 0);
    checkOutput("rstSel", wbSel, 4'hf);
    rstN = 1'b1;

    sendText("A2040Ddeadbeef");
    checkOutput("addr2040", wbAddr, 30'h2040);
    checkOutput("dataDead", wbDataO, 32'hdeadbeef);
    doOp(1'b1, 0, 1, 0, 32'h0, 1'b0);

    sendText("A2040");
    doOp(1'b0, 3, 2, 0, 32'h0123abcd, 1'b0);
    doOp(1'b0, 1, 0, 2, 32'h5555aaaa, 1'b0);
    doOp(1'b0, 0, 0, 3, 32'h0, 1'b0);

    sendText("A123456789a");
    checkOutput("addrWrap", wbAddr, 30'h3456789a);
    sendText("Z");
    sendText("X55\n");
    checkOutput("addrAfterX", wbAddr, 30'h3456789a);
    doOp(1'b0, 2, 1, 0, 32'hcafe0042, 1'b1);
    checkOutput("addrDropped", wbAddr, 30'h3456789a);

    // Reset in the middle of a reply, then in the middle of a bus cycle.
    sendText("A1");
    applyStimulus("R");
    wbRun(0, 0, 0, 32'h89abcdef, 1'b0, 1'b0);
    txBusy = 1'b1;
    @(negedge clk);
    checkOutput("replyHeld", txStb, 1);
    #2 rstN = 1'b0;
    #1 checkOutput("rstMidTx", {txStb, wbCyc}, 0);
    checkOutput("rstMidAddr", wbAddr, 0);
    @(negedge clk);
    rstN = 1'b1; txBusy = 1'b0; modelReset();
    sendText("A5");
    applyStimulus("R");
    wbStall = 1'b1;
    #2 rstN = 1'b0;
    #1 checkOutput("rstMidBus", {wbCyc, wbStb}, 0);
    @(negedge clk);
    rstN = 1'b1; wbStall = 1'b0; modelReset();
    sendText("A1");
    doOp(1'b0, 0, 0, 0, 32'h00000001, 1'b0);

    for (int it = 0; it < 25; it++) begin
      doWrite = 1'($urandom_range(0, 1));
      nd = $urandom_range(1, 10);
      sendChar("A");
      for (int j = 0; j < nd; j++) sendChar(hexChars[$urandom_range(0, 15)]);
      if ($urandom_range(0, 3) == 0) sendChar(8'h20);
      if (doWrite) begin
        sendChar("D");
        for (int j = 0; j < 8; j++) sendChar(hexChars[$urandom_range(0, 15)]);
      end
      if ($urandom_range(0, 4) == 0) begin
        sendChar("X");
        sendChar(hexChars[$urandom_range(0, 15)]);
      end
      checkOutput("addrModel", wbAddr, addrM);
      mode = $urandom_range(0, 7);
      mode = (mode == 0) ? 1 : (mode == 1) ? 2 : 0;
      doOp(doWrite, $urandom_range(0, 3), $urandom_range(0, 3), mode, $urandom,
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
